// File: rtl/alu_stage_pkg.sv
// Shared sizing and FSM state encoding for the ALU operand stage.
package alu_stage_pkg;
    localparam int W    = 32;
    localparam int NREG = 16;
    localparam int AW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;
endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: two async read ports, two write ports (port A beats port B on an address clash).
module alu_regfile #(
    parameter int W    = alu_stage_pkg::W,
    parameter int NREG = alu_stage_pkg::NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_ra_addr,
    output logic [W-1:0]  o_ra_data,
    input  logic [AW-1:0] i_rb_addr,
    output logic [W-1:0]  o_rb_data,
    input  logic          i_wa_en,
    input  logic [AW-1:0] i_wa_addr,
    input  logic [W-1:0]  i_wa_data,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [W-1:0]  i_wb_data
);
    logic [W-1:0] r_mem [NREG];

    // Entry 0 is never written, so it reads as zero forever after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (i_wa_en && (i_wa_addr == AW'(i))) begin
                    r_mem[i] <= i_wa_data;
                end else if (i_wb_en && (i_wb_addr == AW'(i))) begin
                    r_mem[i] <= i_wb_data;
                end
            end
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];
endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch / result writeback stage around an external combinational ALU.
module alu_operand_stage #(
    parameter int W    = alu_stage_pkg::W,
    parameter int NREG = alu_stage_pkg::NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_func,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_func,
    input  logic [W-1:0]  alu_y,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          zero
);
    import alu_stage_pkg::*;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_ready;
    logic          r_done;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [3:0]    r_func;
    logic [AW-1:0] r_rd;
    logic [W-1:0]  r_result;
    logic          r_zero;
    logic          w_accept;
    logic          w_capture;
    logic          w_wb_en;
    logic          w_ready_next;
    logic          w_done_next;
    logic [W-1:0]  w_rs_data;
    logic [W-1:0]  w_rt_data;

    alu_regfile #(.W(W), .NREG(NREG), .AW(AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ra_addr (in_rs),
        .o_ra_data (w_rs_data),
        .i_rb_addr (in_rt),
        .o_rb_data (w_rt_data),
        .i_wa_en   (w_wb_en),
        .i_wa_addr (r_rd),
        .i_wa_data (r_result),
        .i_wb_en   (ld_en),
        .i_wb_addr (ld_addr),
        .i_wb_data (ld_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = (in_valid && r_ready) ? EXEC : IDLE;
            EXEC:    w_next_state = WB;
            WB:      w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Per-state controls; ready and done are precomputed so they leave the block registered.
    always_comb begin
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_wb_en      = 1'b0;
        w_ready_next = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept     = in_valid && r_ready;
                w_ready_next = !(in_valid && r_ready);
            end
            EXEC: begin
                w_capture   = 1'b1;
                w_done_next = 1'b1;
            end
            WB: begin
                w_wb_en      = (r_rd != '0);
                w_ready_next = 1'b1;
            end
            default: begin
                w_ready_next = 1'b0;
            end
        endcase
    end

    // Operand latches hold their value through IDLE until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_func   <= 4'd0;
            r_rd     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_ready <= w_ready_next;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_a    <= w_rs_data;
                r_b    <= w_rt_data;
                r_func <= in_func;
                r_rd   <= in_rd;
            end
            if (w_capture) begin
                r_result <= alu_y;
                r_zero   <= (alu_y == '0);
            end
        end
    end

    assign in_ready = r_ready;
    assign done     = r_done;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_func = r_func;
    assign result   = r_result;
    assign zero     = r_zero;
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter W, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 16, register count; address width AW = log2(NREG) = 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1  operation handshake.
REQ-006 SHALL have ports in_func input 4, in_rs input AW, in_rt input AW, in_rd input AW  operation fields.
REQ-007 SHALL have ports ld_en input 1, ld_addr input AW, ld_data input W  external register load.
REQ-008 SHALL have ports alu_a output W, alu_b output W, alu_func output 4  drive the downstream ALU32 A/B/alu_func.
REQ-009 SHALL have port alu_y  input  W  combinational result returned by ALU32.
REQ-010 SHALL have ports done output 1, result output W, zero output 1  completion pulse, captured result, result==0 flag.

Function
REQ-011 SHALL contain an NREG x W register file; R0 reads 0, writes to R0 discarded.
REQ-012 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE, one cycle per state except IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE ignored.
REQ-014 On in_valid&&in_ready at edge N: latch in_func, in_rd, R[in_rs], R[in_rt] (pre-edge contents, no bypass); enter EXEC.
REQ-015 alu_a/alu_b/alu_func SHALL be driven from the latches, stable from cycle N+1 until next acceptance; held (not cleared) in IDLE.
REQ-016 At end of EXEC: result <= alu_y, zero <= (alu_y==0); enter WB.
REQ-017 In WB: R[rd] <= result (rd!=0), done=1 for exactly that cycle; done=0 in all other cycles.
REQ-018 Latency: acceptance at edge N -> done high in cycle N+2; max throughput one op per 3 cycles; back-to-back ops see prior writeback (no hazard).
REQ-019 ld_en SHALL write R[ld_addr] <= ld_data in any state (ld_addr!=0).
REQ-020 WB writeback and ld_en to the same address in the same cycle: writeback wins; different addresses: both written.
REQ-021 ld write in the acceptance cycle to in_rs/in_rt: latched operand is the old value.

Reset
REQ-022 rst SHALL immediately force FSM=IDLE, all register-file entries, operand/func/rd latches, result, zero, done to 0.
REQ-023 Reset mid-EXEC/WB SHALL discard the pending op: no done pulse, no writeback.
REQ-024 in_ready SHALL be 0 while rst=1 and 1 from the first cycle after release.

Structure
REQ-025 Package alu_stage_pkg SHALL hold W, NREG, AW and the FSM state enum (IDLE, EXEC, WB).
REQ-026 Register file SHALL be sub-module alu_regfile (2 async read ports, 2 write ports, fixed priority per REQ-020).
REQ-027 ALU32 SHALL NOT be instantiated inside; benches connect it or an alu_y stub externally.

Verification
REQ-028 Reset: rst=1 mid-run -> in_ready=0, done=0, result=0, alu_a=alu_b=0; after release issue rs=5 rt=6 -> alu_a=alu_b=0.
REQ-029 Basic: ld R1=0x0000000F, R2=0x00000001; issue rs=1 rt=2 rd=3 func=0000 at edge N; stub alu_y=0x00000010 -> alu_a=0xF, alu_b=0x1 stable from N+1, done at N+2, result=0x10; later issue rs=3 -> alu_a=0x10.
REQ-030 R0: issue rd=0, alu_y=0xDEADBEEF -> done pulses, result=0xDEADBEEF; subsequent rs=0 -> alu_a=0.
REQ-031 Collision: in WB, ld_en to rd=4 with 0x12345678, result 0xA5A5A5A5 -> R4=0xA5A5A5A5; ld to R5 same cycle -> R5=0x12345678.
REQ-032 Throughput/zero: in_valid held high with 4 ops -> acceptances 3 cycles apart, exactly 4 done pulses; alu_y=0 -> zero=1, alu_y=0xFFFFFFFF -> zero=0.
REQ-033 Reset in EXEC: rst pulse after acceptance -> no done, target rd reads 0, in_ready=1 after release.
